// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath: ALU operation codes,
// operand-B and next-PC selector values, and the PC increment constant.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_NOR = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_HOLD   = 2'b11
  } pcsrc_e;

  localparam int unsigned CONST_FOUR = 4;

endpackage

// File: rtl/mips_regfile.sv
// Register file: two combinational read ports, one write port, register 0
// hard-wired to zero. Reads during a same-cycle write return the old value.
module mips_regfile #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  logic [WIDTH-1:0] regs [NREG];

  // NOTE: clearing every entry on reset forces this array into flops instead of
  // a RAM macro; software relies on a zeroed register file, so it is kept here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_datapath_p.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut pipeline registers, inline
// ALU and operand muxes, sticky overflow flag, and the register file.
module mips_datapath_p
  import mips_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter int              NREG     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic             RegDst,
  input  logic             MemtoReg,
  input  logic             RegWrite,
  input  logic             ALUSrcA,
  input  logic             Branch,
  input  logic             BranchNE,
  input  logic             PCWrite,
  input  logic             OvfClr,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       PCSrc,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] RD,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WD,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic             zero
);

  localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] pc, mdr, a, b, alu_out;
  logic [31:0]      ir;
  logic [WIDTH-1:0] rd1, rd2, reg_wd;
  logic [AW-1:0]    reg_wa;
  logic [WIDTH-1:0] sign_imm, src_a, src_b, alu_result, pc_next;
  logic [WIDTH-1:0] sum, diff;
  logic             add_ovf, sub_ovf, pc_en;
  logic [4:0]       shamt;

  alu_ctrl_e alu_op;
  srcb_e     srcb_sel;
  pcsrc_e    pc_sel;

  assign alu_op   = alu_ctrl_e'(ALUControl);
  assign srcb_sel = srcb_e'(ALUSrcB);
  assign pc_sel   = pcsrc_e'(PCSrc);

  assign reg_wa = RegDst ? ir[11 +: AW] : ir[16 +: AW];
  assign reg_wd = MemtoReg ? mdr : alu_out;

  mips_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (ir[21 +: AW]),
    .ra2   (ir[16 +: AW]),
    .we    (RegWrite),
    .wa    (reg_wa),
    .wd    (reg_wd),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  assign sign_imm = {{(WIDTH-16){ir[15]}}, ir[15:0]};
  assign src_a    = ALUSrcA ? a : pc;
  assign shamt    = ir[10:6];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    src_b = b;
    unique case (srcb_sel)
      SRCB_REG:    src_b = b;
      SRCB_FOUR:   src_b = WIDTH'(CONST_FOUR);
      SRCB_IMM:    src_b = sign_imm;
      SRCB_IMM_SH: src_b = sign_imm << 2;
    endcase
  end

  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;
  // Signed overflow: operands agree in sign (add) or differ (sub) and the result flips.
  assign add_ovf = (src_a[MSB] == src_b[MSB]) && (sum[MSB]  != src_a[MSB]);
  assign sub_ovf = (src_a[MSB] != src_b[MSB]) && (diff[MSB] != src_a[MSB]);

  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    unique case (alu_op)
      ALU_ADD: begin alu_result = sum;  overflow = add_ovf; end
      ALU_SUB: begin alu_result = diff; overflow = sub_ovf; end
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_NOR: alu_result = ~(src_a | src_b);
      // The true sign of a-b is the raw sign bit corrected by the overflow bit.
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, diff[MSB] ^ sub_ovf};
      ALU_SLL: alu_result = src_a << shamt;
      ALU_SRL: alu_result = src_a >> shamt;
    endcase
  end

  assign zero  = (alu_result == '0);
  assign pc_en = PCWrite | (Branch & (zero ^ BranchNE));

  always_comb begin
    pc_next = pc;
    unique case (pc_sel)
      PC_ALU:    pc_next = alu_result;
      PC_ALUOUT: pc_next = alu_out;
      PC_JUMP:   pc_next = {pc[WIDTH-1:28], ir[25:0], 2'b00};
      PC_HOLD:   pc_next = pc;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      ir         <= '0;
      mdr        <= '0;
      a          <= '0;
      b          <= '0;
      alu_out    <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (IRWrite) ir <= RD[31:0];
      mdr     <= RD;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
      if (overflow)    ovf_sticky <= 1'b1;
      else if (OvfClr) ovf_sticky <= 1'b0;
      if (pc_en) pc <= pc_next;
    end
  end

  assign Adr = IorD ? alu_out : pc;
  assign WD  = b;

endmodule

// File: tb/tb_mips_datapath_p.sv
// Bench for mips_datapath_p: a 32-bit instance tracked cycle by cycle by an
// arithmetic reference model, plus a 64-bit/8-register instance for width checks.
module tb_mips_datapath_p;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC   = 32'h0;
  localparam logic [63:0] RST_PC64 = 64'h1000;
  localparam logic [31:0] IR_STD   = 32'h0022_0920; // rs=1 rt=2 rd=1 shamt=4
  localparam longint      SMAX     = 64'sd2147483647;
  localparam longint      SMIN     = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, iord, ir_write, reg_dst, mem_to_reg, reg_write;
  logic        alu_src_a, branch, branch_ne, pc_write, ovf_clr;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic [31:0] rd_data, adr, wd;
  logic        overflow, ovf_sticky, zero;

  logic        reset64, iord64, ir_write64, reg_dst64, mem_to_reg64, reg_write64;
  logic        alu_src_a64, branch64, branch_ne64, pc_write64, ovf_clr64;
  logic [1:0]  alu_src_b64, pc_src64;
  logic [2:0]  alu_control64;
  logic [63:0] rd_data64, adr64, wd64;
  logic        overflow64, ovf_sticky64, zero64;

  mips_datapath_p #(.WIDTH(32), .NREG(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .IorD(iord), .IRWrite(ir_write), .RegDst(reg_dst),
    .MemtoReg(mem_to_reg), .RegWrite(reg_write), .ALUSrcA(alu_src_a), .Branch(branch),
    .BranchNE(branch_ne), .PCWrite(pc_write), .OvfClr(ovf_clr), .ALUSrcB(alu_src_b),
    .PCSrc(pc_src), .ALUControl(alu_control), .RD(rd_data), .Adr(adr), .WD(wd),
    .overflow(overflow), .ovf_sticky(ovf_sticky), .zero(zero)
  );

  mips_datapath_p #(.WIDTH(64), .NREG(8), .RESET_PC(RST_PC64)) dut64 (
    .clk(clk), .reset(reset64), .IorD(iord64), .IRWrite(ir_write64), .RegDst(reg_dst64),
    .MemtoReg(mem_to_reg64), .RegWrite(reg_write64), .ALUSrcA(alu_src_a64), .Branch(branch64),
    .BranchNE(branch_ne64), .PCWrite(pc_write64), .OvfClr(ovf_clr64), .ALUSrcB(alu_src_b64),
    .PCSrc(pc_src64), .ALUControl(alu_control64), .RD(rd_data64), .Adr(adr64), .WD(wd64),
    .overflow(overflow64), .ovf_sticky(ovf_sticky64), .zero(zero64)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state for the 32-bit instance.
  logic [31:0] m_pc = '0, m_ir = '0, m_mdr = '0, m_a = '0, m_b = '0, m_aluout = '0;
  logic        m_sticky = 1'b0;
  logic [31:0] m_rf [32];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        ovf, zr;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU behaviour from plain signed arithmetic on 64-bit integers.
  function automatic void model_alu(output logic [31:0] res, output logic ovf);
    logic [31:0] sa_u, sb_u, imm;
    longint      sa, sb, s;
    imm  = {{16{m_ir[15]}}, m_ir[15:0]};
    sa_u = alu_src_a ? m_a : m_pc;
    case (alu_src_b)
      2'd0:    sb_u = m_b;
      2'd1:    sb_u = 32'd4;
      2'd2:    sb_u = imm;
      default: sb_u = imm * 4;
    endcase
    sa  = $signed(sa_u);
    sb  = $signed(sb_u);
    ovf = 1'b0;
    res = '0;
    case (alu_control)
      3'b010: begin s = sa + sb; res = s[31:0]; ovf = (s > SMAX) || (s < SMIN); end
      3'b110: begin s = sa - sb; res = s[31:0]; ovf = (s > SMAX) || (s < SMIN); end
      3'b000: res = sa_u & sb_u;
      3'b001: res = sa_u | sb_u;
      3'b011: res = ~(sa_u | sb_u);
      3'b111: res = (sa < sb) ? 32'd1 : 32'd0;
      3'b100: res = sa_u << m_ir[10:6];
      default: res = sa_u >> m_ir[10:6];
    endcase
  endfunction

  // Advance one clock, update the model, then compare every observable output.
  task automatic step();
    logic [31:0] res, nres, wdat, n_pc, n_a, n_b;
    logic        ovf, nov, pcen;
    logic [4:0]  wa;
    model_alu(res, ovf);
    wa   = reg_dst ? m_ir[15:11] : m_ir[20:16];
    wdat = mem_to_reg ? m_mdr : m_aluout;
    n_a  = m_rf[m_ir[25:21]];
    n_b  = m_rf[m_ir[20:16]];
    pcen = pc_write | (branch & ((res == 32'd0) ^ branch_ne));
    case (pc_src)
      2'd0:    n_pc = res;
      2'd1:    n_pc = m_aluout;
      2'd2:    n_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
      default: n_pc = m_pc;
    endcase
    @(posedge clk);
    if (!reset) begin
      m_pc = RST_PC; m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_aluout = '0;
      m_sticky = 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else begin
      if (ir_write) m_ir = rd_data;
      m_mdr = rd_data; m_a = n_a; m_b = n_b; m_aluout = res;
      if (ovf) m_sticky = 1'b1;
      else if (ovf_clr) m_sticky = 1'b0;
      if (reg_write && wa != 5'd0) m_rf[wa] = wdat;
      if (pcen) m_pc = n_pc;
    end
    #1;
    check("adr", adr, iord ? m_aluout : m_pc);
    check("wd", wd, m_b);
    check("sticky", ovf_sticky, m_sticky);
    model_alu(nres, nov);
    check("overflow", overflow, nov);
    check("zero", zero, nres == 32'd0);
  endtask

  task automatic idle();
    iord = 0; ir_write = 0; reg_dst = 0; mem_to_reg = 0; reg_write = 0;
    alu_src_a = 0; branch = 0; branch_ne = 0; pc_write = 0; ovf_clr = 0;
    alu_src_b = 2'd0; pc_src = 2'd0; alu_control = 3'b000;
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle();
    rd_data = instr; ir_write = 1; step();
    ir_write = 0;
  endtask

  // Load reg1=va (A) and reg2=vb (B) through MDR, with IR_STD in place.
  task automatic load_ab(input logic [31:0] va, input logic [31:0] vb);
    idle();
    rd_data = va; step();
    reg_write = 1; mem_to_reg = 1; reg_dst = 1; rd_data = vb; step();
    reg_dst = 0; step();
    reg_write = 0; step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    reset = 0; rd_data = '0; idle();
    reset64 = 0; iord64 = 0; ir_write64 = 0; reg_dst64 = 0; mem_to_reg64 = 0; reg_write64 = 0;
    alu_src_a64 = 0; branch64 = 0; branch_ne64 = 0; pc_write64 = 0; ovf_clr64 = 0;
    alu_src_b64 = 2'd0; pc_src64 = 2'd0; alu_control64 = 3'b000; rd_data64 = '0;

    vecs[0]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
    vecs[1]  = '{3'b010, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1'b1};
    vecs[2]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[3]  = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1};
    vecs[4]  = '{3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[5]  = '{3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1};
    vecs[6]  = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    vecs[7]  = '{3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0};
    vecs[8]  = '{3'b011, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0, 1'b1};
    vecs[9]  = '{3'b100, 32'h8000_000F, 32'h0000_0000, 32'h0000_00F0, 1'b0, 1'b0};
    vecs[10] = '{3'b101, 32'h8000_000F, 32'h0000_0000, 32'h0800_0000, 1'b0, 1'b0};

    // Reset state.
    step(); step();
    check("rst_adr", adr, RST_PC);
    check("rst_wd", wd, 32'h0);
    check("rst_sticky", ovf_sticky, 1'b0);
    reset = 1;

    // Fetch after reset.
    iord = 0; ir_write = 1; alu_src_a = 0; alu_src_b = 2'd1; alu_control = ALU_ADD;
    pc_write = 1; pc_src = 2'd0; rd_data = 32'h8C01_0004;
    #1 check("fetch_adr", adr, 32'h0);
    step();
    check("fetch_pc", adr, 32'h4);
    idle(); alu_src_b = 2'd2; alu_control = ALU_ADD; step();
    iord = 1; #1 check("fetch_ir_imm", adr, 32'h8);
    idle(); pc_write = 1; pc_src = 2'd2; step();
    check("jump_pc", adr, 32'h0004_0010);

    // ALU operation table.
    fetch(IR_STD);
    foreach (vecs[i]) begin
      load_ab(vecs[i].a, vecs[i].b);
      alu_src_a = 1; alu_src_b = 2'd0; alu_control = vecs[i].op;
      #1;
      check($sformatf("tbl%0d_ovf", i), overflow, vecs[i].ovf);
      check($sformatf("tbl%0d_zero", i), zero, vecs[i].zr);
      step();
      iord = 1; #1;
      check($sformatf("tbl%0d_res", i), adr, vecs[i].res);
      iord = 0;
    end

    // Sticky overflow: set, set-wins-over-clear, clear.
    load_ab(32'h7FFF_FFFF, 32'h1);
    alu_src_a = 1; alu_control = ALU_ADD;
    #1 check("ovf_comb", overflow, 1'b1);
    ovf_clr = 1; step();
    check("ovf_set_wins", ovf_sticky, 1'b1);
    ovf_clr = 0; step();
    check("ovf_sticky_set", ovf_sticky, 1'b1);
    ovf_clr = 1; alu_control = ALU_AND; step();
    check("ovf_cleared", ovf_sticky, 1'b0);

    // bne not taken, then taken; then PC wrap from all-ones.
    load_ab(32'd5, 32'd5);
    alu_src_a = 1; alu_control = ALU_SUB; step();
    branch = 1; branch_ne = 1; pc_src = 2'd1; step();
    check("bne_not_taken", adr, 32'h0004_0010);
    load_ab(32'd5, 32'd6);
    alu_src_a = 1; alu_control = ALU_SUB; step();
    branch = 1; branch_ne = 1; pc_src = 2'd1; step();
    check("bne_taken", adr, 32'hFFFF_FFFF);
    idle(); alu_src_b = 2'd1; alu_control = ALU_ADD; pc_write = 1; step();
    check("pc_wrap", adr, 32'h3);

    // Register 0 ignores writes.
    load_ab(32'h0000_FFFF, 32'h0);
    fetch(32'h0020_0020);
    alu_src_a = 1; alu_control = ALU_OR; step();
    iord = 1; #1 check("r0_aluout", adr, 32'h0000_FFFF);
    iord = 0; reg_write = 1; reg_dst = 1; step();
    reg_write = 0; step();
    check("r0_reads_zero", wd, 32'h0);

    // Reset in the middle of an instruction.
    fetch(IR_STD);
    load_ab(32'h7FFF_FFFF, 32'h1);
    alu_src_a = 1; alu_control = ALU_ADD; step();
    reset = 0; reg_write = 1; pc_write = 1; ir_write = 1; rd_data = 32'hDEAD_BEEF; step();
    reset = 1; idle();
    check("mid_rst_adr", adr, RST_PC);
    check("mid_rst_wd", wd, 32'h0);
    check("mid_rst_sticky", ovf_sticky, 1'b0);

    // 64-bit, 8-register instance.
    check("rst64_adr", adr64, RST_PC64);
    reset64 = 1; alu_src_a64 = 0; alu_src_b64 = 2'd1; alu_control64 = ALU_ADD;
    ir_write64 = 1; rd_data64 = 64'h0000_0000_0009_8000;
    step();
    ir_write64 = 0; iord64 = 1;
    #1 check("rst64_alu", adr64, RST_PC64 + 64'd4);
    alu_src_a64 = 1; alu_src_b64 = 2'd2; alu_control64 = ALU_OR; step();
    check("simm64", adr64, 64'hFFFF_FFFF_FFFF_8000);
    reg_write64 = 1; reg_dst64 = 0; step();
    reg_write64 = 0; ir_write64 = 1; rd_data64 = 64'h0000_0000_0001_0000; step();
    ir_write64 = 0; step();
    check("rt9_is_reg1", wd64, 64'hFFFF_FFFF_FFFF_8000);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      iord = 1'($urandom); ir_write = 1'($urandom); reg_dst = 1'($urandom);
      mem_to_reg = 1'($urandom); reg_write = 1'($urandom); alu_src_a = 1'($urandom);
      branch = 1'($urandom); branch_ne = 1'($urandom); pc_write = 1'($urandom);
      ovf_clr = ($urandom_range(0, 7) == 0);
      alu_src_b = 2'($urandom); pc_src = 2'($urandom); alu_control = 3'($urandom);
      rd_data = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_datapath_p.md
MIPS_DATAPATH_P -- requirements
Module: mips_datapath_p

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data/address width; legal values are 32 and 64.
REQ-002 SHALL have parameter NREG, default 32, meaning register-file depth; must be a power of 2 in the range 2..32.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the PC value after reset.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have control inputs, each 1 bit: IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, BranchNE, PCWrite, OvfClr.
REQ-007 SHALL have control inputs ALUSrcB (2 bits), PCSrc (2 bits) and ALUControl (3 bits).
REQ-008 SHALL have port RD, input, WIDTH bits: memory read data.
REQ-009 SHALL have port Adr, output, WIDTH bits: memory address.
REQ-010 SHALL have port WD, output, WIDTH bits: memory write data.
REQ-011 SHALL have port overflow, output, 1 bit: combinational signed overflow of the current ALU operation.
REQ-012 SHALL have port ovf_sticky, output, 1 bit: latched overflow flag.
REQ-013 SHALL have port zero, output, 1 bit: the ALU result equals 0.

Function
REQ-014 SHALL hold these internal registers: PC, IR (32 bits), MDR, A, B, ALUOut (each WIDTH bits except IR), ovf_sticky and the register file.
REQ-015 SHALL load IR from RD[31:0] when IRWrite=1, and SHALL load MDR, A, B and ALUOut unconditionally on every clock edge.
REQ-016 SHALL take register indices from the low log2(NREG) bits of IR[25:21] (rs), IR[20:16] (rt) and IR[15:11] (rd).
REQ-017 SHALL always read register 0 as 0, and SHALL ignore writes to register 0.
REQ-018 SHALL select the write register as rd when RegDst=1, else rt; write data SHALL be MDR when MemtoReg=1, else ALUOut; the write occurs on the clock edge when RegWrite=1.
REQ-019 SHALL perform a register write and a read of the same register in the same cycle with the old value appearing at the read port; the new value is visible next cycle.
REQ-020 SHALL select SrcA as A when ALUSrcA=1, else PC.
REQ-021 SHALL select SrcB by ALUSrcB: 00 = B, 01 = constant 4, 10 = SignImm (IR[15:0] sign-extended to WIDTH), 11 = SignImm<<2.
REQ-022 SHALL decode ALUControl as: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt (signed; result 1 or 0), 011 = nor, 100 = sll by IR[10:6], 101 = srl by IR[10:6].
REQ-023 SHALL assert overflow only for add/sub on signed operand overflow, and SHALL drive it to 0 for all other ops; slt SHALL give the correct signed result even when the subtraction overflows.
REQ-024 SHALL set ovf_sticky on any clock edge where overflow=1, and SHALL clear it when OvfClr=1; if both occur in the same cycle, set wins.
REQ-025 SHALL compute PCEn = PCWrite | (Branch & (zero ^ BranchNE)), and SHALL load PC only when PCEn=1.
REQ-026 SHALL select the next PC by PCSrc: 00 = ALU result, 01 = ALUOut, 10 = {PC[WIDTH-1:28], IR[25:0], 2'b00}, 11 = hold current PC.
REQ-027 SHALL drive Adr as ALUOut when IorD=1, else PC; WD SHALL equal B.
REQ-028 SHALL handle arithmetic modulo 2^WIDTH, so the PC wraps from all-ones+4 to 3 without error.

Reset
REQ-029 SHALL, while reset=0 at a clock edge, set PC to RESET_PC, and set IR, MDR, A, B, ALUOut, ovf_sticky and all registers to 0.
REQ-030 SHALL let reset override every write enable; asserting reset mid-instruction discards all in-flight state.
REQ-031 SHALL, on the first cycle after reset with ALUSrcA=0, ALUSrcB=01, ALUControl=010, give Adr = RESET_PC and an ALU result of RESET_PC+4.

Structure
REQ-032 SHALL place the ALUControl encoding enum, the ALUSrcB and PCSrc enums, and the constant 4 in package mips_pkg.
REQ-033 SHALL implement the register file as sub-module mips_regfile, parameters WIDTH and NREG, with 2 read ports and 1 write port; the ALU and muxes stay inline.

Verification
REQ-034 Fetch after reset: IorD=0, IRWrite=1, ALUSrcB=01, add, PCWrite=1, RD=0x8C010004 -> Adr=0, then PC=4, IR=0x8C010004.
REQ-035 Overflow: A=0x7FFFFFFF, B=1, add -> overflow=1, ovf_sticky=1 next cycle; OvfClr=1 with no overflow -> ovf_sticky=0.
REQ-036 bne: A=5, B=5, sub, Branch=1, BranchNE=1 -> PC unchanged; with B=6 -> PC=ALUOut.
REQ-037 Writing register 0: RegWrite=1 with rd=0 and ALUOut=0xFFFF -> register 0 still reads 0.
REQ-038 WIDTH=64, NREG=8: SignImm=0x8000 -> SrcB=0xFFFFFFFFFFFF8000; rt field=9 addresses register 1.
